// File: rtl/mem_cmd_pkg.sv
// mem_cmd_pkg: command codes, default hold-off timings and decode helpers shared by the scheduler
package mem_cmd_pkg;
  localparam int CMD_NOP = 0;
  localparam int CMD_ACT = 1;
  localparam int CMD_RD  = 2;
  localparam int CMD_WR  = 3;
  localparam int CMD_PRE = 4;
  localparam int CMD_REF = 5;
  localparam int T_ACT_DEF = 18;
  localparam int T_RD_DEF  = 6;
  localparam int T_WR_DEF  = 8;
  localparam int T_PRE_DEF = 12;
  localparam int T_REF_DEF = 40;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  function automatic logic cmd_legal(input logic [31:0] code);
    return code >= 32'(CMD_ACT) && code <= 32'(CMD_REF);
  endfunction
  function automatic int cmd_holdoff(input logic [31:0] code, input int t_act = T_ACT_DEF,
                                     input int t_rd = T_RD_DEF, input int t_wr = T_WR_DEF,
                                     input int t_pre = T_PRE_DEF, input int t_ref = T_REF_DEF);
    return code == 32'(CMD_ACT) ? t_act :
           code == 32'(CMD_RD)  ? t_rd  :
           code == 32'(CMD_WR)  ? t_wr  :
           code == 32'(CMD_PRE) ? t_pre :
           code == 32'(CMD_REF) ? t_ref : 0;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin winner search starting at a rotating pointer that advances past each accepted winner
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] ptr_q, ptr_d, j;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'(int'(ptr_q) + k >= NUM_REQ ? int'(ptr_q) + k - NUM_REQ : int'(ptr_q) + k);
      if (!any && req[j]) begin
        any = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
    ptr_d = en ? (idx == IW'(NUM_REQ - 1) ? '0 : idx + IW'(1)) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/mem_cmd_scheduler.sv
// mem_cmd_scheduler: round-robin issue of one requester command at a time, then a per-command hold-off window
module mem_cmd_scheduler
  import mem_cmd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 4,
  parameter int ADDR_W  = 24,
  parameter int TIMER_W = 8,
  parameter int T_ACT   = T_ACT_DEF,
  parameter int T_RD    = T_RD_DEF,
  parameter int T_WR    = T_WR_DEF,
  parameter int T_PRE   = T_PRE_DEF,
  parameter int T_REF   = T_REF_DEF
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cmd_valid,
  output logic [CMD_W-1:0]           cmd_code,
  output logic [ADDR_W-1:0]          cmd_addr,
  output logic [$clog2(NUM_REQ)-1:0] cmd_src,
  output logic                       busy,
  output logic                       err_illegal
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TMAX = 2 ** TIMER_W - 1;
  if (T_ACT < 1 || T_ACT > TMAX || T_RD < 1 || T_RD > TMAX || T_WR < 1 || T_WR > TMAX ||
      T_PRE < 1 || T_PRE > TMAX || T_REF < 1 || T_REF > TMAX) begin : g_bad_timing
    $error("mem_cmd_scheduler: hold-off timing does not fit the timer");
  end
  state_e state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic vld_q, vld_d, err_q, err_d;
  logic [CMD_W-1:0] code_q, code_d, win_cmd;
  logic [ADDR_W-1:0] addr_q, addr_d, win_addr;
  logic [IW-1:0] src_q, src_d, win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic win_any, idle, accept, legal;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .req   (req_valid),
    .en    (accept),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );
  assign idle = state_q == S_IDLE;
  assign accept = idle && win_any;
  assign win_cmd = req_cmd[win_idx*CMD_W +: CMD_W];
  assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign legal = cmd_legal(32'(win_cmd));
  // reset gating keeps the accept strobe quiet while reset is held
  assign req_ready = win_grant & {NUM_REQ{idle && !sys_rst}};
  assign cmd_valid = vld_q;
  assign cmd_code = code_q;
  assign cmd_addr = addr_q;
  assign cmd_src = src_q;
  assign busy = !idle;
  assign err_illegal = err_q;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    addr_d = addr_q;
    src_d = src_q;
    if (accept) begin
      vld_d = legal;
      err_d = !legal;
      state_d = legal ? S_ISSUE : S_IDLE;
      code_d = legal ? win_cmd : code_q;
      addr_d = legal ? win_addr : addr_q;
      src_d = legal ? win_idx : src_q;
    end else if (state_q == S_ISSUE) begin
      timer_d = TIMER_W'(cmd_holdoff(32'(code_q), T_ACT, T_RD, T_WR, T_PRE, T_REF) - 1);
      state_d = S_WAIT;
    end else if (state_q == S_WAIT) begin
      timer_d = timer_q == '0 ? timer_q : timer_q - TIMER_W'(1);
      state_d = timer_q == '0 ? S_IDLE : S_WAIT;
    end
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= '0;
      addr_q <= '0;
      src_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      vld_q <= vld_d;
      err_q <= err_d;
      code_q <= code_d;
      addr_q <= addr_d;
      src_q <= src_d;
    end
endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// tb_mem_cmd_scheduler: directed scenarios with hand-computed cycle positions for accepts, issues and busy windows
module tb_mem_cmd_scheduler;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [15:0] req_cmd = '0;
  logic [95:0] req_addr = '0;
  logic [3:0] req_ready;
  logic cmd_valid, busy, err_illegal;
  logic [3:0] cmd_code;
  logic [23:0] cmd_addr;
  logic [1:0] cmd_src;
  logic [3:0] oneshot = '0;
  logic [3:0] rdy_s = '0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic busy_at [0:2047];
  logic vld_at [0:2047];
  logic err_at [0:2047];
  logic [3:0] rdy_at [0:2047];
  logic [3:0] code_at [0:2047];
  logic [23:0] addr_at [0:2047];
  logic [1:0] src_at [0:2047];

  mem_cmd_scheduler dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_addr    (cmd_addr),
    .cmd_src     (cmd_src),
    .busy        (busy),
    .err_illegal (err_illegal)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    rdy_s = req_ready;
    if (cyc < 2048) begin
      busy_at[cyc] = busy;
      vld_at[cyc] = cmd_valid;
      err_at[cyc] = err_illegal;
      rdy_at[cyc] = req_ready;
      code_at[cyc] = cmd_code;
      addr_at[cyc] = cmd_addr;
      src_at[cyc] = cmd_src;
    end
  end

  // one-shot requesters withdraw right after the edge that accepted them
  always @(posedge sys_clk) begin
    #1;
    req_valid = req_valid & ~(rdy_s & oneshot);
  end

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic do_reset;
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    req_valid = '0;
    oneshot = '0;
    @(posedge sys_clk); #2;
    sys_rst = 1'b0;
  endtask

  task automatic drain;
    int k;
    @(posedge sys_clk); #2;
    req_valid = '0;
    k = 0;
    @(negedge sys_clk);
    while (busy && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset;
    int n;
    req_valid = 4'b1111;
    repeat (3) @(posedge sys_clk);
    #2;
    checks++;
    if ({cmd_valid, busy, err_illegal, req_ready, cmd_code, cmd_addr, cmd_src} !== 36'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {cmd_valid, busy, err_illegal, req_ready, cmd_code, cmd_addr, cmd_src});
    end
    req_valid = '0;
    sys_rst = 1'b0;
    n = cyc;
    req_cmd[3:0] = 4'd1;
    req_addr[23:0] = 24'h000123;
    oneshot = 4'b0001;
    req_valid = 4'b0001;
    goto_cycle(n + 12);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    sys_rst = 1'b1;
    req_cmd[7:0] = 8'h22;
    oneshot = 4'b0011;
    req_valid = 4'b0011;
    #1;
    checks++;
    if ({cmd_valid, busy, err_illegal, req_ready, cmd_code, cmd_addr, cmd_src} !== 36'h0) begin
      errors++; $display("FAIL reset_midflight: got %h want 0", {cmd_valid, busy, err_illegal, req_ready, cmd_code, cmd_addr, cmd_src});
    end
    @(posedge sys_clk); #2;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr_grant: got %b want 0001", req_ready); end
    drain;
  endtask

  task automatic test_single_act;
    int n, b;
    @(posedge sys_clk); #2;
    n = cyc;
    req_cmd[3:0] = 4'd1;
    req_addr[23:0] = 24'h000123;
    oneshot = '0;
    req_valid = 4'b0001;
    goto_cycle(n + 21);
    drain;
    checks++;
    if (rdy_at[n] !== 4'b0001) begin errors++; $display("FAIL act_ready: got %b want 0001", rdy_at[n]); end
    checks++;
    if ({vld_at[n], vld_at[n + 1]} !== 2'b01) begin errors++; $display("FAIL act_strobe: got %b want 01", {vld_at[n], vld_at[n + 1]}); end
    checks++;
    if ({code_at[n + 1], addr_at[n + 1], src_at[n + 1]} !== {4'd1, 24'h000123, 2'd0}) begin
      errors++; $display("FAIL act_fields: got %h want %h", {code_at[n + 1], addr_at[n + 1], src_at[n + 1]}, {4'd1, 24'h000123, 2'd0});
    end
    b = 0;
    for (int c = n; c <= n + 20; c++) b += int'(busy_at[c]);
    checks++;
    if (b != 19 || busy_at[n + 1] !== 1'b1 || busy_at[n + 19] !== 1'b1) begin errors++; $display("FAIL act_busy: got %0d cycles want 19 over N+1..N+19", b); end
    checks++;
    if (rdy_at[n + 19] !== 4'b0000 || rdy_at[n + 20] !== 4'b0001) begin
      errors++; $display("FAIL act_next_accept: got %b/%b want 0000/0001", rdy_at[n + 19], rdy_at[n + 20]);
    end
    checks++;
    if ({vld_at[n + 5], code_at[n + 5], addr_at[n + 5]} !== {1'b0, 4'd1, 24'h000123}) begin
      errors++; $display("FAIL act_hold: got %h want %h", {vld_at[n + 5], code_at[n + 5], addr_at[n + 5]}, {1'b0, 4'd1, 24'h000123});
    end
  endtask

  task automatic test_round_robin;
    int n, v;
    do_reset;
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      req_cmd[i*4 +: 4] = 4'd2;
      req_addr[i*24 +: 24] = 24'h000100 + 24'(i);
    end
    oneshot = '0;
    req_valid = 4'b1111;
    goto_cycle(n + 33);
    drain;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rdy_at[n + 8*k] !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", k, rdy_at[n + 8*k], 4'(1 << (k % 4)));
      end
      checks++;
      if ({vld_at[n + 8*k + 1], src_at[n + 8*k + 1], addr_at[n + 8*k + 1]} !== {1'b1, 2'(k % 4), 24'h000100 + 24'(k % 4)}) begin
        errors++; $display("FAIL rr_issue%0d: got %h want %h", k, {vld_at[n + 8*k + 1], src_at[n + 8*k + 1], addr_at[n + 8*k + 1]}, {1'b1, 2'(k % 4), 24'h000100 + 24'(k % 4)});
      end
    end
    v = 0;
    for (int c = n + 1; c <= n + 33; c++) v += int'(vld_at[c]);
    checks++;
    if (v != 5) begin errors++; $display("FAIL rr_pulse_count: got %0d want 5", v); end
  endtask

  task automatic test_illegal;
    int n, m;
    do_reset;
    n = cyc;
    req_cmd[11:8] = 4'd7;
    req_cmd[15:12] = 4'd2;
    req_addr[95:72] = 24'hABCDEF;
    oneshot = 4'b1100;
    req_valid = 4'b1100;
    goto_cycle(n + 4);
    drain;
    checks++;
    if (rdy_at[n] !== 4'b0100) begin errors++; $display("FAIL ill_ready: got %b want 0100", rdy_at[n]); end
    checks++;
    if ({err_at[n], err_at[n + 1], err_at[n + 2]} !== 3'b010) begin
      errors++; $display("FAIL ill_err_pulse: got %b want 010", {err_at[n], err_at[n + 1], err_at[n + 2]});
    end
    checks++;
    if ({vld_at[n + 1], busy_at[n + 1], rdy_at[n + 1]} !== {1'b0, 1'b0, 4'b1000}) begin
      errors++; $display("FAIL ill_next_accept: got %b want 001000", {vld_at[n + 1], busy_at[n + 1], rdy_at[n + 1]});
    end
    checks++;
    if ({vld_at[n + 2], code_at[n + 2], addr_at[n + 2], src_at[n + 2]} !== {1'b1, 4'd2, 24'hABCDEF, 2'd3}) begin
      errors++; $display("FAIL ill_follow_issue: got %h want %h", {vld_at[n + 2], code_at[n + 2], addr_at[n + 2], src_at[n + 2]}, {1'b1, 4'd2, 24'hABCDEF, 2'd3});
    end
    @(posedge sys_clk); #2;
    m = cyc;
    req_cmd[3:0] = 4'd0;
    oneshot = 4'b0001;
    req_valid = 4'b0001;
    goto_cycle(m + 3);
    drain;
    checks++;
    if ({rdy_at[m], err_at[m + 1], vld_at[m + 1], busy_at[m + 1]} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ill_nop: got %b want 0001100", {rdy_at[m], err_at[m + 1], vld_at[m + 1], busy_at[m + 1]});
    end
  endtask

  task automatic test_pointer_order;
    int m, n, v;
    do_reset;
    m = cyc;
    req_cmd[7:4] = 4'hF;
    oneshot = 4'b0010;
    req_valid = 4'b0010;
    @(posedge sys_clk); #2;
    n = cyc;
    req_cmd[7:4] = 4'd3;
    req_addr[47:24] = 24'h00BEEF;
    req_cmd[15:12] = 4'd5;
    req_addr[95:72] = 24'h333333;
    oneshot = '0;
    req_valid = 4'b1010;
    goto_cycle(n + 53);
    drain;
    checks++;
    if ({err_at[m + 1], rdy_at[n]} !== {1'b1, 4'b1000}) begin errors++; $display("FAIL ptr_first_grant: got %b want 11000", {err_at[m + 1], rdy_at[n]}); end
    checks++;
    if ({vld_at[n + 1], code_at[n + 1], src_at[n + 1], addr_at[n + 1]} !== {1'b1, 4'd5, 2'd3, 24'h333333}) begin
      errors++; $display("FAIL ptr_ref_issue: got %h want %h", {vld_at[n + 1], code_at[n + 1], src_at[n + 1], addr_at[n + 1]}, {1'b1, 4'd5, 2'd3, 24'h333333});
    end
    v = 0;
    for (int c = n + 2; c <= n + 42; c++) v += int'(vld_at[c]);
    checks++;
    if (v != 0 || rdy_at[n + 42] !== 4'b0010) begin errors++; $display("FAIL ptr_second_grant: got %0d/%b want 0/0010", v, rdy_at[n + 42]); end
    checks++;
    if ({vld_at[n + 43], code_at[n + 43], src_at[n + 43], addr_at[n + 43]} !== {1'b1, 4'd3, 2'd1, 24'h00BEEF}) begin
      errors++; $display("FAIL ptr_wr_issue: got %h want %h", {vld_at[n + 43], code_at[n + 43], src_at[n + 43], addr_at[n + 43]}, {1'b1, 4'd3, 2'd1, 24'h00BEEF});
    end
    checks++;
    if ({rdy_at[n + 51], rdy_at[n + 52], vld_at[n + 53], src_at[n + 53]} !== {4'b0000, 4'b1000, 1'b1, 2'd3}) begin
      errors++; $display("FAIL ptr_repeat: got %b want 00001000111", {rdy_at[n + 51], rdy_at[n + 52], vld_at[n + 53], src_at[n + 53]});
    end
  endtask

  task automatic test_back_to_back;
    int n, v, b;
    @(posedge sys_clk); #2;
    n = cyc;
    req_cmd[3:0] = 4'd4;
    oneshot = '0;
    req_valid = 4'b0001;
    goto_cycle(n + 15);
    drain;
    v = 0;
    b = 0;
    for (int c = n + 1; c <= n + 15; c++) v += int'(vld_at[c]);
    for (int c = n; c <= n + 14; c++) b += int'(busy_at[c]);
    checks++;
    if ({vld_at[n + 1], vld_at[n + 15]} !== 2'b11 || v != 2) begin errors++; $display("FAIL pre_spacing: got %0d pulses want 2 at N+1,N+15", v); end
    checks++;
    if (b != 13 || busy_at[n + 14] !== 1'b0) begin errors++; $display("FAIL pre_busy: got %0d want 13", b); end
    @(posedge sys_clk); #2;
    n = cyc;
    req_cmd[3:0] = 4'd5;
    req_valid = 4'b0001;
    goto_cycle(n + 43);
    drain;
    v = 0;
    b = 0;
    for (int c = n + 1; c <= n + 43; c++) v += int'(vld_at[c]);
    for (int c = n; c <= n + 42; c++) b += int'(busy_at[c]);
    checks++;
    if ({vld_at[n + 1], vld_at[n + 43]} !== 2'b11 || v != 2) begin errors++; $display("FAIL ref_spacing: got %0d pulses want 2 at N+1,N+43", v); end
    checks++;
    if (b != 41 || busy_at[n + 42] !== 1'b0) begin errors++; $display("FAIL ref_busy: got %0d want 41", b); end
  endtask

  initial begin
    test_reset;
    test_single_act;
    test_round_robin;
    test_illegal;
    test_pointer_order;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
